// File: rtl/pipeline_controller.sv
// Decode-stage control for a 5-stage pipeline.
// Covers hazard stalls, forwarding, branch flush and halt drain.
module pipeline_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] opcodeD,
  input  logic [3:0] srcAdd1D,
  input  logic [3:0] srcAdd2D,
  input  logic [3:0] destAddD,
  output logic       enable,
  output logic       branchC,
  output logic       flushC,
  output logic       RegWriteC,
  output logic       MemWriteC,
  output logic       MemToRegC,
  output logic       immediateC,
  output logic       forwardC,
  output logic [1:0] alufuncC,
  output logic       halted,
  output logic [7:0] stallCnt
);

  typedef enum logic [2:0] {
    IDLE, RUN, BFLUSH, DRAIN, HALTED
  } state_t;

  typedef struct packed {
    logic       valid;
    logic [3:0] dest;
    logic       regWrite;
    logic       memToReg;
  } shadow_t;

  state_t     state;
  shadow_t    shE, shM;
  logic [1:0] drainCnt;

  logic       dRegWrite, dMemToReg, dMemWrite, dImm;
  logic [1:0] dAlu;
  logic       isBr, isHalt, isNop;

  always_comb begin
    dRegWrite = 1'b0;
    dMemToReg = 1'b0;
    dMemWrite = 1'b0;
    dImm      = 1'b0;
    dAlu      = 2'b00;
    isBr      = 1'b0;
    isHalt    = 1'b0;
    isNop     = 1'b0;
    case (opcodeD)
      4'b0001: dRegWrite = 1'b1;
      4'b0010: begin dRegWrite = 1'b1; dAlu = 2'b01; end
      4'b0011: begin dRegWrite = 1'b1; dAlu = 2'b10; end
      4'b0100: begin dRegWrite = 1'b1; dAlu = 2'b11; end
      4'b0101: begin dRegWrite = 1'b1; dImm = 1'b1; end
      4'b0110: begin
        dRegWrite = 1'b1;
        dMemToReg = 1'b1;
        dImm      = 1'b1;
      end
      4'b0111: begin dMemWrite = 1'b1; dImm = 1'b1; end
      4'b1000: isBr   = 1'b1;
      4'b1111: isHalt = 1'b1;
      default: isNop  = 1'b1;
    endcase
  end

  logic chk1, chk2;
  logic eHit1, eHit2, mHit1, mHit2;
  logic eAlu, hazard, fwd, issue;

  // Register 0 is hard-wired, so it never matches a producer.
  assign chk1  = srcAdd1D != 4'd0;
  assign chk2  = (srcAdd2D != 4'd0) && !dImm;
  assign eHit1 = shE.valid && chk1 && (srcAdd1D == shE.dest);
  assign eHit2 = shE.valid && chk2 && (srcAdd2D == shE.dest);
  assign mHit1 = shM.valid && shM.regWrite && chk1
                 && (srcAdd1D == shM.dest);
  assign mHit2 = shM.valid && shM.regWrite && chk2
                 && (srcAdd2D == shM.dest);
  assign eAlu  = shE.regWrite && !shE.memToReg;

  assign hazard = (state == RUN)
                  && ((shE.memToReg && (eHit1 || eHit2))
                      || (eHit2 && eAlu)
                      || mHit1 || mHit2);
  assign fwd    = (state == RUN) && !hazard && eHit1 && eAlu;
  assign issue  = (state == RUN) && !hazard
                  && !isNop && !isBr && !isHalt;
  assign halted = state == HALTED;

  always_comb begin
    enable     = 1'b0;
    flushC     = 1'b1;
    branchC    = 1'b0;
    RegWriteC  = 1'b0;
    MemWriteC  = 1'b0;
    MemToRegC  = 1'b0;
    immediateC = 1'b0;
    forwardC   = 1'b0;
    alufuncC   = 2'b00;
    case (state)
      RUN: begin
        if (!hazard && !isHalt) begin
          enable     = 1'b1;
          flushC     = 1'b0;
          branchC    = isBr;
          RegWriteC  = dRegWrite;
          MemWriteC  = dMemWrite;
          MemToRegC  = dMemToReg;
          immediateC = dImm;
          forwardC   = fwd;
          alufuncC   = dAlu;
        end
      end
      BFLUSH:  enable = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      shE      <= '0;
      shM      <= '0;
      drainCnt <= 2'd0;
      stallCnt <= 8'd0;
    end else begin
      shM <= shE;
      shE <= issue ? {1'b1, destAddD, dRegWrite, dMemToReg} : '0;
      if (hazard && stallCnt != 8'hFF)
        stallCnt <= stallCnt + 8'd1;
      case (state)
        IDLE, HALTED: begin
          if (start) begin
            state    <= RUN;
            stallCnt <= 8'd0;
          end
        end
        RUN: begin
          if (!hazard && isBr)
            state <= BFLUSH;
          else if (!hazard && isHalt) begin
            state    <= DRAIN;
            drainCnt <= 2'd3;
          end
        end
        BFLUSH: state <= RUN;
        DRAIN: begin
          // Last drain cycle is the one that takes the count to zero.
          if (drainCnt != 2'd0)
            drainCnt <= drainCnt - 2'd1;
          if (drainCnt <= 2'd1)
            state <= HALTED;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_controller.sv
// Directed bench for pipeline_controller.
// Control bundle: en br fl rw mw mr im fw alu[1:0].
module tb_pipeline_controller;

  logic       clk = 1'b0;
  logic       reset, start;
  logic [3:0] op, s1, s2, d;
  logic       enable, branchC, flushC, RegWriteC, MemWriteC;
  logic       MemToRegC, immediateC, forwardC, halted;
  logic [1:0] alufuncC;
  logic [7:0] stallCnt;
  logic [9:0] ctl;
  int         errs = 0;
  int         checks = 0;

  localparam logic [3:0] NOP = 4'h0, ADD = 4'h1, SUB = 4'h2;
  localparam logic [3:0] AND = 4'h3, OR = 4'h4, ADDI = 4'h5;
  localparam logic [3:0] LOAD = 4'h6, STORE = 4'h7, BR = 4'h8;
  localparam logic [3:0] HALT = 4'hF;

  localparam logic [9:0] C_IDLE = 10'b0010000000;
  localparam logic [9:0] C_NOP  = 10'b1000000000;
  localparam logic [9:0] C_ADD  = 10'b1001000000;

  pipeline_controller dut (
    .clk(clk), .reset(reset), .start(start),
    .opcodeD(op), .srcAdd1D(s1), .srcAdd2D(s2), .destAddD(d),
    .enable(enable), .branchC(branchC), .flushC(flushC),
    .RegWriteC(RegWriteC), .MemWriteC(MemWriteC),
    .MemToRegC(MemToRegC), .immediateC(immediateC),
    .forwardC(forwardC), .alufuncC(alufuncC),
    .halted(halted), .stallCnt(stallCnt)
  );

  assign ctl = {enable, branchC, flushC, RegWriteC, MemWriteC,
                MemToRegC, immediateC, forwardC, alufuncC};

  always #5 clk = ~clk;

  task automatic drive(input logic [3:0] o, dd, a, b);
    @(negedge clk);
    start = 1'b0;
    op = o; d = dd; s1 = a; s2 = b;
    #1;
  endtask

  task automatic test_reset;
    @(negedge clk); reset = 1'b1; start = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (ctl !== C_IDLE) begin
      errs++; $display("FAIL rst_ctl got %b want %b", ctl, C_IDLE);
    end
    checks++;
    if (halted !== 1'b0 || stallCnt !== 8'd0) begin
      errs++;
      $display("FAIL rst_state got h=%b s=%0d want h=0 s=0",
               halted, stallCnt);
    end
    @(negedge clk); reset = 1'b0; start = 1'b0; #1;
    checks++;
    if (ctl !== C_IDLE) begin
      errs++; $display("FAIL idle_ctl got %b want %b", ctl, C_IDLE);
    end
  endtask

  task automatic test_basic;
    @(negedge clk); start = 1'b1;
    drive(ADD, 1, 2, 3);
    checks++;
    if (ctl !== C_ADD) begin
      errs++; $display("FAIL add_ctl got %b want %b", ctl, C_ADD);
    end
  endtask

  task automatic test_forward;
    drive(SUB, 4, 1, 5);
    checks++;
    if (ctl !== 10'b1001000101) begin
      errs++;
      $display("FAIL fwd_ctl got %b want %b", ctl, 10'b1001000101);
    end
    drive(SUB, 4, 5, 1);
    checks++;
    if (ctl !== C_IDLE) begin
      errs++; $display("FAIL mstall_ctl got %b want %b", ctl, C_IDLE);
    end
    drive(SUB, 4, 5, 1);
    checks++;
    if (ctl !== 10'b1001000001 || stallCnt !== 8'd1) begin
      errs++;
      $display("FAIL mstall_issue got %b/%0d want %b/1",
               ctl, stallCnt, 10'b1001000001);
    end
    drive(ADD, 0, 2, 3);
    drive(SUB, 4, 0, 0);
    checks++;
    if (ctl !== 10'b1001000001) begin
      errs++;
      $display("FAIL r0_ctl got %b want %b", ctl, 10'b1001000001);
    end
    drive(NOP, 0, 0, 0);
    checks++;
    if (ctl !== C_NOP) begin
      errs++; $display("FAIL nop_ctl got %b want %b", ctl, C_NOP);
    end
    drive(NOP, 0, 0, 0);
  endtask

  task automatic test_load_use;
    drive(LOAD, 2, 7, 0);
    checks++;
    if (ctl !== 10'b1001011000) begin
      errs++;
      $display("FAIL load_ctl got %b want %b", ctl, 10'b1001011000);
    end
    for (int i = 0; i < 2; i++) begin
      drive(ADD, 3, 2, 2);
      checks++;
      if (ctl !== C_IDLE || stallCnt !== 8'(1 + i)) begin
        errs++;
        $display("FAIL lu_stall%0d got %b/%0d want %b/%0d",
                 i, ctl, stallCnt, C_IDLE, 1 + i);
      end
    end
    drive(ADD, 3, 2, 2);
    checks++;
    if (ctl !== C_ADD || stallCnt !== 8'd3) begin
      errs++;
      $display("FAIL lu_issue got %b/%0d want %b/3",
               ctl, stallCnt, C_ADD);
    end
  endtask

  task automatic test_isa;
    logic [3:0] ops [5];
    logic [9:0] exp [5];
    ops = '{STORE, ADDI, AND, OR, 4'hA};
    exp = '{10'b1000101000, 10'b1001001000, 10'b1001000010,
            10'b1001000011, C_NOP};
    for (int i = 0; i < 5; i++) begin
      drive(ops[i], 4'(5 + i), 0, 0);
      checks++;
      if (ctl !== exp[i]) begin
        errs++;
        $display("FAIL isa_op%h got %b want %b", ops[i], ctl, exp[i]);
      end
    end
  endtask

  task automatic test_branch;
    drive(BR, 0, 0, 0);
    checks++;
    if (ctl !== 10'b1100000000) begin
      errs++;
      $display("FAIL br_ctl got %b want %b", ctl, 10'b1100000000);
    end
    drive(ADD, 1, 2, 3);
    checks++;
    if (ctl !== 10'b1010000000) begin
      errs++;
      $display("FAIL bflush_ctl got %b want %b", ctl, 10'b1010000000);
    end
    drive(ADD, 1, 2, 3);
    checks++;
    if (ctl !== C_ADD) begin
      errs++; $display("FAIL br_resume got %b want %b", ctl, C_ADD);
    end
  endtask

  task automatic test_halt;
    drive(NOP, 0, 0, 0);
    drive(HALT, 0, 0, 0);
    checks++;
    if (ctl !== C_IDLE || halted !== 1'b0) begin
      errs++;
      $display("FAIL halt_ctl got %b/%b want %b/0", ctl, halted, C_IDLE);
    end
    for (int i = 0; i < 3; i++) begin
      drive(ADD, 1, 2, 3);
      if (i == 0) start = 1'b1;
      checks++;
      if (ctl !== C_IDLE || halted !== 1'b0) begin
        errs++;
        $display("FAIL drain%0d got %b/%b want %b/0",
                 i, ctl, halted, C_IDLE);
      end
    end
    drive(ADD, 1, 2, 3);
    checks++;
    if (ctl !== C_IDLE || halted !== 1'b1) begin
      errs++;
      $display("FAIL halted got %b/%b want %b/1", ctl, halted, C_IDLE);
    end
    start = 1'b1;
    drive(ADD, 1, 2, 3);
    checks++;
    if (ctl !== C_ADD || halted !== 1'b0 || stallCnt !== 8'd0) begin
      errs++;
      $display("FAIL restart got %b/%b/%0d want %b/0/0",
               ctl, halted, stallCnt, C_ADD);
    end
  endtask

  task automatic test_saturate;
    for (int i = 0; i < 127; i++) begin
      drive(LOAD, 2, 7, 0);
      repeat (3) drive(ADD, 3, 2, 2);
    end
    checks++;
    if (stallCnt !== 8'd254) begin
      errs++; $display("FAIL sat254 got %0d want 254", stallCnt);
    end
    drive(LOAD, 2, 7, 0);
    drive(ADD, 3, 2, 2);
    checks++;
    if (ctl !== C_IDLE || stallCnt !== 8'd254) begin
      errs++;
      $display("FAIL sat_stall got %b/%0d want %b/254",
               ctl, stallCnt, C_IDLE);
    end
    repeat (2) drive(ADD, 3, 2, 2);
    checks++;
    if (stallCnt !== 8'd255) begin
      errs++; $display("FAIL sat255 got %0d want 255", stallCnt);
    end
    drive(LOAD, 2, 7, 0);
    repeat (3) drive(ADD, 3, 2, 2);
    checks++;
    if (stallCnt !== 8'd255) begin
      errs++; $display("FAIL sat_hold got %0d want 255", stallCnt);
    end
  endtask

  task automatic test_drain_reset;
    drive(NOP, 0, 0, 0);
    drive(HALT, 0, 0, 0);
    drive(NOP, 0, 0, 0);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (ctl !== C_IDLE || halted !== 1'b0 || stallCnt !== 8'd0) begin
      errs++;
      $display("FAIL drst got %b/%b/%0d want %b/0/0",
               ctl, halted, stallCnt, C_IDLE);
    end
    @(negedge clk); #1;
    @(negedge clk); reset = 1'b0; #1;
    @(negedge clk); #1;
    checks++;
    if (halted !== 1'b0 || ctl !== C_IDLE) begin
      errs++;
      $display("FAIL drst_hold got %b/%b want %b/0", ctl, halted, C_IDLE);
    end
    start = 1'b1;
    drive(ADD, 1, 2, 3);
    checks++;
    if (ctl !== C_ADD) begin
      errs++; $display("FAIL drst_run got %b want %b", ctl, C_ADD);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0;
    op = NOP; d = 0; s1 = 0; s2 = 0;
    test_reset();
    test_basic();
    test_forward();
    test_load_use();
    test_isa();
    test_branch();
    test_halt();
    test_saturate();
    test_drain_reset();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/pipeline_controller.md
PIPELINE_CONTROLLER -- requirements
Module: pipeline_controller

Interface
REQ-001 Port clk, input, 1: single clock; all state SHALL update on its rising edge.
REQ-002 Port reset, input, 1: synchronous, active-high; SHALL be sampled only on clk rising edge.
REQ-003 Port start, input, 1: begins or restarts execution from IDLE or HALTED.
REQ-004 Port opcodeD, input, 4: opcode of the instruction in the decode register.
REQ-005 Port srcAdd1D / srcAdd2D, input, 4 each: decode-stage source register addresses.
REQ-006 Port destAddD, input, 4: decode-stage destination register address.
REQ-007 Port enable, output, 1: PC and decode register enable.
REQ-008 Ports branchC, flushC, RegWriteC, MemWriteC, MemToRegC, immediateC, forwardC, output, 1 each: datapath controls for the decode-stage instruction.
REQ-009 Port alufuncC, output, 2: ALU function for the decode-stage instruction.
REQ-010 Port halted, output, 1: high while in HALTED.
REQ-011 Port stallCnt, output, 8: saturating count of hazard-stall cycles.

Function
REQ-012 Opcode map SHALL be: 0000 NOP; 0001 ADD; 0010 SUB; 0011 AND; 0100 OR; 0101 ADDI; 0110 LOAD; 0111 STORE; 1000 BR (unconditional); 1111 HALT; all others decode as NOP.
REQ-013 alufuncC SHALL be ADD/ADDI/LOAD/STORE=00, SUB=01, AND=10, OR=11; all other cases 00.
REQ-014 Decoded controls: ALU ops, ADDI and LOAD set RegWriteC; LOAD sets MemToRegC; STORE sets MemWriteC; ADDI, LOAD and STORE set immediateC.
REQ-015 FSM states SHALL be IDLE, RUN, BFLUSH, DRAIN and HALTED; reset enters IDLE.
REQ-016 IDLE and HALTED: enable=0, flushC=1, all other controls 0; start=1 moves to RUN next cycle and clears stallCnt.
REQ-017 An E-shadow and an M-shadow register (valid, dest, regwrite, memtoreg) SHALL track in-flight instructions; each cycle M<=E, and E<=decode info if issued, else invalid.
REQ-018 "Issued" SHALL mean state RUN, no hazard, and opcode neither NOP nor BR nor HALT.
REQ-019 Hazard in RUN SHALL be any of: a checked source equals valid E dest with E.memtoreg (load-use); srcAdd2D equals valid ALU E dest; a checked source equals valid M dest with M.regwrite. srcAdd2D SHALL be checked only when immediateC=0.
REQ-020 Hazard SHALL force enable=0, flushC=1 and all write/branch controls to 0; the FSM stays in RUN; stallCnt increments and saturates at 255.
REQ-021 forwardC SHALL be 1 when there is no hazard and srcAdd1D equals the valid E dest with E.regwrite=1 and E.memtoreg=0.
REQ-022 Register address 0 SHALL never create a hazard or forward.
REQ-023 BR in RUN without hazard: branchC=1, enable=1, no write controls; next state BFLUSH.
REQ-024 BFLUSH: enable=1, flushC=1, all other controls 0, discarding the wrong-path instruction; next state RUN.
REQ-025 HALT in RUN without hazard: enable=0, flushC=1; next state DRAIN with a 2-bit drain counter loaded with 3.
REQ-026 DRAIN: enable=0, flushC=1; counter decrements each cycle; leaves for HALTED when the counter is 0.
REQ-027 Controls SHALL be combinational from state, opcodeD and shadows; latency from opcode to control is 0 cycles.
REQ-028 start SHALL be ignored in RUN, BFLUSH and DRAIN.

Reset
REQ-029 When reset=1, the next edge SHALL give state=IDLE, both shadows invalid, drain counter=0 and stallCnt=0.
REQ-030 During and after reset, outputs SHALL be enable=0, flushC=1, halted=0, all other controls 0 and alufuncC=00; reset SHALL take priority over start and over any state, including mid-DRAIN.

Verification
REQ-031 Reset, then start; ADD r1,r2,r3 decoded -> RegWriteC=1, alufuncC=00, enable=1, forwardC=0.
REQ-032 ADD r1 followed by SUB r4,r1,r5 -> on the SUB cycle forwardC=1 with no stall; then SUB r4,r5,r1 -> exactly 1 stall cycle and stallCnt=1.
REQ-033 LOAD r2 followed by ADD r3,r2,r2 -> 2 stall cycles (E match, then M match), enable=0 and flushC=1 in each, then issue.
REQ-034 BR -> branchC=1 for 1 cycle, then flushC=1 with enable=1 for 1 cycle, then RUN.
REQ-035 HALT -> 3 DRAIN cycles with enable=0, then halted=1; start -> RUN; reset asserted mid-DRAIN -> IDLE next cycle and halted stays 0.
REQ-036 257 consecutive hazard cycles -> stallCnt=255.
